mdu_unit: RTL and testbench

//   Multi-cycle multiply/divide unit with HI/LO registers, for the MIPS datapath.

---
 rtl/mdu_unit_pkg.sv | 38 +++
 rtl/mdu_arith.sv | 80 ++++++++
 rtl/mdu_unit.sv | 97 +++++++++
 tb/tb_mdu_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operand width, op encodings,
// default operation latencies and the HI/LO payload type.
package mdu_unit_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned OP_W            = 3;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MFHI  = 3'd6,
        MDU_MFLO  = 3'd7
    } mdu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Two's-complement negate, also used to take magnitudes (0x80000000 maps to itself).
    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
        return (~x) + XLEN'(1);
    endfunction

    // Width of a down-counter that must hold values 0..max_cycles.
    function automatic int unsigned cnt_width(input int unsigned mult_c, input int unsigned div_c);
        int unsigned m;
        m = (mult_c > div_c) ? mult_c : div_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: produces the HI/LO pair a long MDU op will commit,
// including the divide-by-zero hold of the current HI/LO.
module mdu_arith
    import mdu_unit_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  hilo_t           cur_i,
    output hilo_t           res_o
);

    logic [2*XLEN-1:0] a_sx;
    logic [2*XLEN-1:0] b_sx;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_u;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   div_s;
    logic [XLEN-1:0]   div_u;
    logic [XLEN-1:0]   q_mag;
    logic [XLEN-1:0]   r_mag;
    logic [XLEN-1:0]   q_u;
    logic [XLEN-1:0]   r_u;
    logic              b_zero;

    // Low 64 bits of a 64x64 product equal the exact signed/unsigned 32x32 product.
    always_comb begin
        a_sx   = {{XLEN{a_i[XLEN-1]}}, a_i};
        b_sx   = {{XLEN{b_i[XLEN-1]}}, b_i};
        prod_s = a_sx * b_sx;
        prod_u = {XLEN'(0), a_i} * {XLEN'(0), b_i};
    end

    // Signed divide via magnitudes so that 0x80000000 / -1 wraps instead of overflowing.
    always_comb begin
        b_zero = (b_i == '0);
        a_neg  = a_i[XLEN-1];
        b_neg  = b_i[XLEN-1];
        a_mag  = a_neg ? neg32(a_i) : a_i;
        b_mag  = b_neg ? neg32(b_i) : b_i;
        div_s  = b_zero ? XLEN'(1) : b_mag;
        div_u  = b_zero ? XLEN'(1) : b_i;
        q_mag  = a_mag / div_s;
        r_mag  = a_mag % div_s;
        q_u    = a_i / div_u;
        r_u    = a_i % div_u;
    end

    always_comb begin
        res_o = cur_i;
        case (mdu_op_e'(op_i))
            MDU_MULT: begin
                res_o.hi = prod_s[2*XLEN-1:XLEN];
                res_o.lo = prod_s[XLEN-1:0];
            end
            MDU_MULTU: begin
                res_o.hi = prod_u[2*XLEN-1:XLEN];
                res_o.lo = prod_u[XLEN-1:0];
            end
            MDU_DIV: begin
                if (!b_zero) begin
                    res_o.lo = (a_neg ^ b_neg) ? neg32(q_mag) : q_mag;
                    res_o.hi = a_neg ? neg32(r_mag) : r_mag;
                end
            end
            MDU_DIVU: begin
                if (!b_zero) begin
                    res_o.lo = q_u;
                    res_o.hi = r_u;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed at
// accept, held in pending registers, and committed when the latency counter expires.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] mdu_op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] mdu_out
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    hilo_t            hilo_q;
    hilo_t            hilo_d;
    hilo_t            pend_q;
    hilo_t            pend_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    hilo_t            arith_res;
    mdu_op_e          op;

    assign op = mdu_op_e'(mdu_op);

    mdu_arith u_arith (
        .op_i  (mdu_op),
        .a_i   (A),
        .b_i   (B),
        .cur_i (hilo_q),
        .res_o (arith_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hilo_q <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            hilo_q <= hilo_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // While counting, new requests are dropped; commit happens on the 1->0 step.
    always_comb begin
        hilo_d = hilo_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                hilo_d = pend_q;
            end
        end else if (start) begin
            case (op)
                MDU_MULT, MDU_MULTU: begin
                    pend_d = arith_res;
                    cnt_d  = CNT_W'(MULT_CYCLES);
                end
                MDU_DIV, MDU_DIVU: begin
                    pend_d = arith_res;
                    cnt_d  = CNT_W'(DIV_CYCLES);
                end
                MDU_MTHI: hilo_d.hi = A;
                MDU_MTLO: hilo_d.lo = A;
                default: ;
            endcase
        end
    end

    assign busy = (cnt_q != '0);
    assign hi   = hilo_q.hi;
    assign lo   = hilo_q.lo;

    // Read port for mfhi/mflo; shows the committed value even while busy.
    always_comb begin
        mdu_out = '0;
        if (start) begin
            if (op == MDU_MFHI) begin
                mdu_out = hilo_q.hi;
            end else if (op == MDU_MFLO) begin
                mdu_out = hilo_q.lo;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: a vector table of single ops plus hand-written
// sequences for requests during busy and reset mid-operation.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          exp_cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    mdu_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mdu_out (mdu_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one op for a single cycle, check mdu_out while it is presented,
    // then count busy cycles (bounded) and check the committed HI/LO.
    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        mdu_op = v.op;
        A      = v.a;
        B      = v.b;
        start  = 1'b1;
        #1;
        check32({v.name, " mdu_out"}, mdu_out, v.exp_out);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_int({v.name, " busy cycles"}, n, v.exp_cycles);
        check32({v.name, " hi"}, hi, v.exp_hi);
        check32({v.name, " lo"}, lo, v.exp_lo);
    endtask

    initial begin
        int n_busy;
        int n_late;
        vec_t v;

        reset  = 1'b1;
        start  = 1'b0;
        mdu_op = 3'd0;
        A      = '0;
        B      = '0;

        vecs.push_back('{"mthi",        MDU_MTHI,  32'h12345678, 32'h0,        0,  32'h12345678, 32'h00000000, 32'h0});
        vecs.push_back('{"div by 0",    MDU_DIV,   32'd9,        32'd0,        10, 32'h12345678, 32'h00000000, 32'h0});
        vecs.push_back('{"mult -3*5",   MDU_MULT,  32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1, 32'h0});
        vecs.push_back('{"mfhi a",      MDU_MFHI,  32'h0,        32'h0,        0,  32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFFF});
        vecs.push_back('{"mflo a",      MDU_MFLO,  32'h0,        32'h0,        0,  32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFF1});
        vecs.push_back('{"multu",       MDU_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE, 32'h0});
        vecs.push_back('{"divu 7/2",    MDU_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003, 32'h0});
        vecs.push_back('{"div -7/2",    MDU_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0});
        vecs.push_back('{"div min/-1",  MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 32'h0});
        vecs.push_back('{"mtlo",        MDU_MTLO,  32'hCAFEBABE, 32'h0,        0,  32'h00000000, 32'hCAFEBABE, 32'h0});
        vecs.push_back('{"divu by 0",   MDU_DIVU,  32'd5,        32'd0,        10, 32'h00000000, 32'hCAFEBABE, 32'h0});
        vecs.push_back('{"mult max^2",  MDU_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001, 32'h0});
        vecs.push_back('{"mult min^2",  MDU_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000, 32'h0});
        vecs.push_back('{"multu ff^2",  MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, 32'h0});
        vecs.push_back('{"div 7/-2",    MDU_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 32'h0});
        vecs.push_back('{"mfhi b",      MDU_MFHI,  32'h0,        32'h0,        0,  32'h00000001, 32'hFFFFFFFD, 32'h00000001});
        vecs.push_back('{"mflo b",      MDU_MFLO,  32'h0,        32'h0,        0,  32'h00000001, 32'hFFFFFFFD, 32'hFFFFFFFD});

        repeat (3) @(negedge clk);
        #1;
        check32("reset hi", hi, 32'h0);
        check32("reset lo", lo, 32'h0);
        check32("reset busy", 32'(busy), 32'h0);
        check32("reset mdu_out", mdu_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // mdu_out is gated by start.
        @(negedge clk);
        mdu_op = MDU_MFLO;
        start  = 1'b0;
        #1;
        check32("mflo without start", mdu_out, 32'h0);

        // Requests while busy are dropped; mflo during busy shows the old LO.
        @(negedge clk);
        mdu_op = MDU_MULT; A = 32'd2; B = 32'd3; start = 1'b1;
        n_busy = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (busy) n_busy++;
            start = 1'b0;
            if (c == 2) begin mdu_op = MDU_MTLO; A = 32'h0000AAAA; start = 1'b1; end
            if (c == 3) begin mdu_op = MDU_DIVU; A = 32'd8; B = 32'd2; start = 1'b1; end
            if (c == 4) begin
                mdu_op = MDU_MFLO; start = 1'b1;
                #1;
                check32("busy mflo old value", mdu_out, 32'hFFFFFFFD);
                check32("busy lo unchanged", lo, 32'hFFFFFFFD);
            end
        end
        check_int("ignored ops busy cycles", n_busy, 5);
        check32("ignored ops busy end", 32'(busy), 32'h0);
        check32("ignored ops hi", hi, 32'h0);
        check32("ignored ops lo", lo, 32'h6);

        // Asynchronous reset mid-divide aborts it with no later commit.
        @(negedge clk);
        mdu_op = MDU_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        n_busy = 0;
        n_late = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= 4 && busy) n_busy++;
            if (c > 4 && busy) n_late++;
            if (c == 4) begin
                #2;
                reset = 1'b1;
                #1;
                check32("async reset busy", 32'(busy), 32'h0);
                check32("async reset hi", hi, 32'h0);
                check32("async reset lo", lo, 32'h0);
            end
            if (c == 5) reset = 1'b0;
        end
        check_int("pre-reset busy cycles", n_busy, 4);
        check_int("post-reset busy cycles", n_late, 0);
        check32("no late commit hi", hi, 32'h0);
        check32("no late commit lo", lo, 32'h0);

        v = '{"mult 4*4 after reset", MDU_MULT, 32'd4, 32'd4, 5, 32'h0, 32'd16, 32'h0};
        run_vec(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
